// File: rtl/dsweep_pkg.sv
// Shared definitions for the distributive-law sweep controller: FSM state
// encoding and the width helpers derived from the operand width W.
package dsweep_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Result width of op1/op2: W-bit by (W+1)-bit product
    function automatic int unsigned res_w(input int unsigned w);
        return 2 * w + 1;
    endfunction

    // Packed {in1,in2,in3} vector width
    function automatic int unsigned vec_w(input int unsigned w);
        return 3 * w;
    endfunction

    // Counter width, wide enough to hold 2^(3W)
    function automatic int unsigned cnt_w(input int unsigned w);
        return 3 * w + 1;
    endfunction

endpackage

// File: rtl/distrib_check_core.sv
// Combinational distributive-law checker:
//   op1 = in1*(in2+in3), op2 = in1*in2 + in1*in3 (op2[0] optionally flipped),
//   z   = (op1 == op2).
module distrib_check_core
    import dsweep_pkg::*;
#(
    parameter int unsigned W = 4
) (
    input  logic [W-1:0] in1,
    input  logic [W-1:0] in2,
    input  logic [W-1:0] in3,
    input  logic         flip,
    output logic [2*W:0] op1,
    output logic [2*W:0] op2,
    output logic         z
);

    localparam int unsigned RES_W = res_w(W);

    logic [W:0]       sum;
    logic [RES_W-1:0] in1_x;
    logic [RES_W-1:0] in2_x;
    logic [RES_W-1:0] in3_x;
    logic [RES_W-1:0] sum_x;
    logic [RES_W-1:0] op2_raw;

    // Full-width arithmetic for both sides of the identity
    always_comb begin
        sum     = {1'b0, in2} + {1'b0, in3};
        in1_x   = {{(W + 1){1'b0}}, in1};
        in2_x   = {{(W + 1){1'b0}}, in2};
        in3_x   = {{(W + 1){1'b0}}, in3};
        sum_x   = {{W{1'b0}}, sum};
        op1     = in1_x * sum_x;
        op2_raw = (in1_x * in2_x) + (in1_x * in3_x);
        op2     = op2_raw ^ {{(RES_W - 1){1'b0}}, flip};
        z       = (op1 == op2);
    end

endmodule

// File: rtl/distributive_sweep_ctrl.sv
// Sweep sequencer: walks every {in1,in2,in3} vector through the checker core,
// one per clock, registers the result into S1 and accumulates counts and the
// first failing vector. Reports busy/done/pass to the harness.
module distributive_sweep_ctrl
    import dsweep_pkg::*;
#(
    parameter int unsigned W = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           abort,
    input  logic           inject_en,
    input  logic [3*W-1:0] inject_vec,
    output logic           busy,
    output logic           done,
    output logic           pass,
    output logic [3*W:0]   checked_count,
    output logic [3*W:0]   mismatch_count,
    output logic           first_fail_valid,
    output logic [3*W-1:0] first_fail_vec,
    output logic [2*W:0]   fail_op1,
    output logic [2*W:0]   fail_op2
);

    localparam int unsigned RES_W = res_w(W);
    localparam int unsigned VEC_W = vec_w(W);
    localparam int unsigned CNT_W = cnt_w(W);

    logic [1:0]       state_q,     state_d;
    logic [VEC_W-1:0] vec_q,       vec_d;
    logic             s1_valid_q,  s1_valid_d;
    logic             s1_z_q,      s1_z_d;
    logic [VEC_W-1:0] s1_vec_q,    s1_vec_d;
    logic [RES_W-1:0] s1_op1_q,    s1_op1_d;
    logic [RES_W-1:0] s1_op2_q,    s1_op2_d;
    logic [CNT_W-1:0] checked_q,   checked_d;
    logic [CNT_W-1:0] mismatch_q,  mismatch_d;
    logic             ff_valid_q,  ff_valid_d;
    logic [VEC_W-1:0] ff_vec_q,    ff_vec_d;
    logic [RES_W-1:0] ff_op1_q,    ff_op1_d;
    logic [RES_W-1:0] ff_op2_q,    ff_op2_d;
    logic             done_q,      done_d;

    logic             core_flip;
    logic [RES_W-1:0] core_op1;
    logic [RES_W-1:0] core_op2;
    logic             core_z;

    assign core_flip = inject_en && (vec_q == inject_vec);

    distrib_check_core #(
        .W (W)
    ) u_core (
        .in1  (vec_q[3*W-1:2*W]),
        .in2  (vec_q[2*W-1:W]),
        .in3  (vec_q[W-1:0]),
        .flip (core_flip),
        .op1  (core_op1),
        .op2  (core_op2),
        .z    (core_z)
    );

    // Next-state: FSM, vector issue into S1, and accumulation of S1 results
    always_comb begin
        state_d    = state_q;
        vec_d      = vec_q;
        s1_valid_d = 1'b0;
        s1_z_d     = s1_z_q;
        s1_vec_d   = s1_vec_q;
        s1_op1_d   = s1_op1_q;
        s1_op2_d   = s1_op2_q;
        checked_d  = checked_q;
        mismatch_d = mismatch_q;
        ff_valid_d = ff_valid_q;
        ff_vec_d   = ff_vec_q;
        ff_op1_d   = ff_op1_q;
        ff_op2_d   = ff_op2_q;
        done_d     = done_q;

        // S1 holds a result only in RUN/DRAIN; abort drops it unaccumulated
        if (s1_valid_q && !abort) begin
            checked_d = checked_q + CNT_W'(1);
            if (!s1_z_q) begin
                mismatch_d = mismatch_q + CNT_W'(1);
                if (!ff_valid_q) begin
                    ff_valid_d = 1'b1;
                    ff_vec_d   = s1_vec_q;
                    ff_op1_d   = s1_op1_q;
                    ff_op2_d   = s1_op2_q;
                end
            end
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start && !abort) begin
                    state_d    = ST_RUN;
                    vec_d      = '0;
                    checked_d  = '0;
                    mismatch_d = '0;
                    ff_valid_d = 1'b0;
                    ff_vec_d   = '0;
                    ff_op1_d   = '0;
                    ff_op2_d   = '0;
                    done_d     = 1'b0;
                end else if (state_q == ST_DONE) begin
                    // done rises one edge after entering DONE
                    done_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    s1_valid_d = 1'b1;
                    s1_z_d     = core_z;
                    s1_vec_d   = vec_q;
                    s1_op1_d   = core_op1;
                    s1_op2_d   = core_op2;
                    if (vec_q == '1) begin
                        state_d = ST_DRAIN;
                    end else begin
                        vec_d = vec_q + VEC_W'(1);
                    end
                end
            end
            default: begin
                state_d = abort ? ST_IDLE : ST_DONE;
            end
        endcase
    end

    // State registers with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            vec_q      <= '0;
            s1_valid_q <= 1'b0;
            s1_z_q     <= 1'b0;
            s1_vec_q   <= '0;
            s1_op1_q   <= '0;
            s1_op2_q   <= '0;
            checked_q  <= '0;
            mismatch_q <= '0;
            ff_valid_q <= 1'b0;
            ff_vec_q   <= '0;
            ff_op1_q   <= '0;
            ff_op2_q   <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            vec_q      <= vec_d;
            s1_valid_q <= s1_valid_d;
            s1_z_q     <= s1_z_d;
            s1_vec_q   <= s1_vec_d;
            s1_op1_q   <= s1_op1_d;
            s1_op2_q   <= s1_op2_d;
            checked_q  <= checked_d;
            mismatch_q <= mismatch_d;
            ff_valid_q <= ff_valid_d;
            ff_vec_q   <= ff_vec_d;
            ff_op1_q   <= ff_op1_d;
            ff_op2_q   <= ff_op2_d;
            done_q     <= done_d;
        end
    end

    // busy also spans the single DONE cycle before done is raised
    assign busy             = (state_q == ST_RUN) || (state_q == ST_DRAIN) ||
                              ((state_q == ST_DONE) && !done_q);
    assign done             = done_q;
    assign pass             = done_q && (mismatch_q == '0);
    assign checked_count    = checked_q;
    assign mismatch_count   = mismatch_q;
    assign first_fail_valid = ff_valid_q;
    assign first_fail_vec   = ff_vec_q;
    assign fail_op1         = ff_op1_q;
    assign fail_op2         = ff_op2_q;

endmodule

// File: tb/tb_distributive_sweep_ctrl.sv
// Directed bench for distributive_sweep_ctrl (W=4 main instance, W=2 second).
module tb_distributive_sweep_ctrl;

    localparam int BUDGET = 5000;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, abort, inject_en;
    logic [11:0] inject_vec;
    logic        busy, done, pass, ffv;
    logic [12:0] checked, mismatch;
    logic [11:0] ffvec;
    logic [8:0]  op1, op2;

    logic        start2, inject_en2;
    logic [5:0]  inject_vec2;
    logic        busy2, done2, pass2, ffv2;
    logic [6:0]  checked2, mismatch2;
    logic [5:0]  ffvec2;
    logic [4:0]  op1_2, op2_2;

    int n_cmp = 0;
    int n_err = 0;
    int edges;

    always #5 clk = ~clk;

    distributive_sweep_ctrl #(.W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .inject_en(inject_en), .inject_vec(inject_vec),
        .busy(busy), .done(done), .pass(pass),
        .checked_count(checked), .mismatch_count(mismatch),
        .first_fail_valid(ffv), .first_fail_vec(ffvec),
        .fail_op1(op1), .fail_op2(op2)
    );

    distributive_sweep_ctrl #(.W(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .abort(1'b0),
        .inject_en(inject_en2), .inject_vec(inject_vec2),
        .busy(busy2), .done(done2), .pass(pass2),
        .checked_count(checked2), .mismatch_count(mismatch2),
        .first_fail_valid(ffv2), .first_fail_vec(ffvec2),
        .fail_op1(op1_2), .fail_op2(op2_2)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Start pulse sampled at edge 0; optional extra start pokes sampled at
    // edges poke1+1 / poke2+1; returns the first edge after which done=1.
    task automatic run_sweep(input int poke1, input int poke2, output int n);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (!done && n < BUDGET) begin
            @(posedge clk); #1;
            n++;
            start = (n == poke1 || n == poke2);
        end
        start = 1'b0;
    endtask

    // Start, then abort sampled at edge `at`
    task automatic abort_at(input int at);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (at - 1) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; inject_en = 1'b0; inject_vec = '0;
        start2 = 1'b0; inject_en2 = 1'b0; inject_vec2 = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_checked", 32'(checked), 32'd0);
        check_val("rst_ffv", 32'(ffv), 32'd0);

        // 1: clean sweep
        run_sweep(0, 0, edges);
        check_val("t1_done_edge", 32'(edges), 32'd4098);
        check_val("t1_checked", 32'(checked), 32'd4096);
        check_val("t1_mismatch", 32'(mismatch), 32'd0);
        check_val("t1_pass", 32'(pass), 32'd1);
        check_val("t1_ffv", 32'(ffv), 32'd0);
        check_val("t1_busy", 32'(busy), 32'd0);

        // 2: fault injected at 0xAF9: 10*(15+9)=240
        inject_en = 1'b1; inject_vec = 12'hAF9;
        run_sweep(0, 0, edges);
        inject_en = 1'b0;
        check_val("t2_done_edge", 32'(edges), 32'd4098);
        check_val("t2_mismatch", 32'(mismatch), 32'd1);
        check_val("t2_ffv", 32'(ffv), 32'd1);
        check_val("t2_ffvec", 32'(ffvec), 32'hAF9);
        check_val("t2_op1", 32'(op1), 32'h0F0);
        check_val("t2_op2", 32'(op2), 32'h0F1);
        check_val("t2_pass", 32'(pass), 32'd0);
        check_val("t2_checked", 32'(checked), 32'd4096);

        // 3: abort at cycle 100, then restart
        abort_at(100);
        check_val("t3_busy", 32'(busy), 32'd0);
        check_val("t3_done", 32'(done), 32'd0);
        check_val("t3_cnt_range", 32'(checked >= 13'd97 && checked <= 13'd99), 32'd1);
        repeat (5) @(posedge clk);
        #1 check_val("t3_cnt_hold", 32'(checked >= 13'd97 && checked <= 13'd99), 32'd1);
        check_val("t3_ffv", 32'(ffv), 32'd0);
        run_sweep(0, 0, edges);
        check_val("t3_restart_edge", 32'(edges), 32'd4098);
        check_val("t3_restart_cnt", 32'(checked), 32'd4096);

        // 4a: start+abort together in DONE -> no effect
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        repeat (4) @(posedge clk);
        #1 check_val("t4_done_hold", 32'(done), 32'd1);
        check_val("t4_done_cnt", 32'(checked), 32'd4096);
        // 4b: reach IDLE with partial counts, then start+abort together
        abort_at(100);
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        repeat (4) @(posedge clk);
        #1 check_val("t4_idle_busy", 32'(busy), 32'd0);
        check_val("t4_idle_cnt", 32'(checked >= 13'd97 && checked <= 13'd99), 32'd1);
        // 4c: start pulses during RUN are ignored
        run_sweep(10, 500, edges);
        check_val("t4_run_edge", 32'(edges), 32'd4098);
        check_val("t4_run_cnt", 32'(checked), 32'd4096);
        check_val("t4_run_pass", 32'(pass), 32'd1);

        // 5: reset mid-sweep at cycle 2000
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (1999) @(posedge clk);
        #1 check_val("t5_busy_pre", 32'(busy), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_val("t5_busy", 32'(busy), 32'd0);
        check_val("t5_done", 32'(done), 32'd0);
        check_val("t5_checked", 32'(checked), 32'd0);
        check_val("t5_mismatch", 32'(mismatch), 32'd0);
        check_val("t5_ffv", 32'(ffv), 32'd0);
        check_val("t5_ffvec", 32'(ffvec), 32'd0);
        check_val("t5_op", 32'({op1, op2}), 32'd0);
        repeat (3) @(posedge clk);
        #1 check_val("t5_idle", 32'(busy), 32'd0);
        run_sweep(0, 0, edges);
        check_val("t5_edge", 32'(edges), 32'd4098);
        check_val("t5_cnt", 32'(checked), 32'd4096);
        check_val("t5_pass", 32'(pass), 32'd1);

        // 6: W=2 instance, fault at 0x3F: 3*(3+3)=18
        inject_en2 = 1'b1; inject_vec2 = 6'h3F;
        start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        edges = 0;
        while (!done2 && edges < 200) begin
            @(posedge clk); #1;
            edges++;
        end
        check_val("t6_done_edge", 32'(edges), 32'd66);
        check_val("t6_checked", 32'(checked2), 32'd64);
        check_val("t6_mismatch", 32'(mismatch2), 32'd1);
        check_val("t6_ffvec", 32'(ffvec2), 32'h3F);
        check_val("t6_op1", 32'(op1_2), 32'h12);
        check_val("t6_op2", 32'(op2_2), 32'h13);
        check_val("t6_pass", 32'(pass2), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
